// File: rtl/excep_unit_pkg.sv
// Shared definitions for the AM->WB exception controller: MIPS ExcCodes,
// default exception vector, FSM state encoding and event classification.
package excep_unit_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } excep_state_e;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_INT  = 2'd1,
    EV_EXC  = 2'd2,
    EV_ERET = 2'd3
  } event_kind_e;

  // AM carries at most one exception code, so the ordering between the
  // synchronous exceptions is already resolved upstream; interrupts win
  // over any code, and any code wins over ERET.
  function automatic event_kind_e classify(input logic int_req,
                                           input logic [4:0] code,
                                           input logic eret);
    event_kind_e kind;
    kind = EV_NONE;
    if (int_req)            kind = EV_INT;
    else if (code != 5'h00) kind = EV_EXC;
    else if (eret)          kind = EV_ERET;
    return kind;
  endfunction

  function automatic logic has_badvaddr(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/excep_unit_if.sv
// AM-stage event inputs, fetch redirect handshake and CP0 commit bus of the
// exception controller. master = exception unit, slave = pipeline/CP0 side.
interface excep_unit_if #(
  parameter int ADDR_W = 32
);
  logic              am_valid;
  logic [4:0]        am_excep_code;
  logic              am_is_instload;
  logic [ADDR_W-1:0] am_pc;
  logic              am_in_bd;
  logic [ADDR_W-1:0] am_data_addr;
  logic              am_eret;
  logic [ADDR_W-1:0] epc_in;

  logic              redirect_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic              cp0_we_excep;
  logic [4:0]        cp0_excep_code;
  logic [ADDR_W-1:0] cp0_epc;
  logic              cp0_bd;
  logic              cp0_we_badvaddr;
  logic [ADDR_W-1:0] cp0_badvaddr;
  logic              cp0_clr_exl;

  modport master (
    input  am_valid, am_excep_code, am_is_instload, am_pc, am_in_bd,
           am_data_addr, am_eret, epc_in, redirect_ready,
    output redirect_valid, redirect_pc, cp0_we_excep, cp0_excep_code,
           cp0_epc, cp0_bd, cp0_we_badvaddr, cp0_badvaddr, cp0_clr_exl
  );

  modport slave (
    output am_valid, am_excep_code, am_is_instload, am_pc, am_in_bd,
           am_data_addr, am_eret, epc_in, redirect_ready,
    input  redirect_valid, redirect_pc, cp0_we_excep, cp0_excep_code,
           cp0_epc, cp0_bd, cp0_we_badvaddr, cp0_badvaddr, cp0_clr_exl
  );
endinterface

// File: rtl/excep_unit_int_sync.sv
// excep_int_sync: per-line STAGES-deep synchroniser for asynchronous level
// interrupt requests, cleared by the asynchronous active-low reset.
module excep_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_line
      logic [STAGES-1:0] chain_reg;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) chain_reg <= '0;
        else         chain_reg <= {chain_reg[STAGES-2:0], async_in[gi]};
      end

      assign sync_out[gi] = chain_reg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/excep_unit.sv
// Sequential exception/interrupt controller at the AM->WB boundary: IDLE ->
// COMMIT -> REDIRECT. Optional CP0 Count/Compare timer on IP7 via EXCEP_TIMER_EN.
module excep_unit
  import excep_unit_pkg::*;
#(
  parameter int                NUM_HW_INT  = 6,
  parameter int                SYNC_STAGES = 2,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR  = ADDR_W'(EXC_VECTOR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic [1:0]            sw_int,
  input  logic [7:0]            int_mask,
  input  logic                  status_ie,
  input  logic                  status_exl,
  excep_unit_if.master          bus,
`ifdef EXCEP_TIMER_EN
  output logic [31:0]           cp0_count_o,
  input  logic                  compare_we,
  input  logic [31:0]           compare_wdata,
`endif
  output logic                  flush,
  output logic                  busy
);

  logic [NUM_HW_INT-1:0] sync_out;
  logic [5:0]            hw_sync;
  logic [5:0]            ip_hw;

  excep_int_sync #(
    .WIDTH  (NUM_HW_INT),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (hw_int),
    .sync_out (sync_out)
  );

  generate
    if (NUM_HW_INT < 6) begin : g_pad
      assign hw_sync = {{(6-NUM_HW_INT){1'b0}}, sync_out};
    end else begin : g_full
      assign hw_sync = sync_out;
    end
  endgenerate

`ifdef EXCEP_TIMER_EN
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        half_reg;
  logic        timer_reg;

  // Count advances on every second clock; the timer flag is raised on the
  // edge where Count reaches Compare, so a stale equality never re-arms it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg   <= '0;
      compare_reg <= '0;
      half_reg    <= 1'b0;
      timer_reg   <= 1'b0;
    end else begin
      half_reg <= ~half_reg;
      if (half_reg) count_reg <= count_reg + 32'd1;
      if (compare_we) compare_reg <= compare_wdata;
      if (compare_we)
        timer_reg <= 1'b0;
      else if (half_reg && (count_reg + 32'd1 == compare_reg))
        timer_reg <= 1'b1;
    end
  end

  assign cp0_count_o = count_reg;
  assign ip_hw       = {hw_sync[5] | timer_reg, hw_sync[4:0]};
`else
  assign ip_hw = hw_sync;
`endif

  logic        int_req;
  event_kind_e ev_kind;
  logic        trigger;

  excep_state_e state_reg, state_next;

  assign int_req = (|({ip_hw, sw_int} & int_mask)) & status_ie & ~status_exl;
  assign ev_kind = classify(int_req, bus.am_excep_code, bus.am_eret);
  // Gating with resetn keeps flush low while reset is held.
  assign trigger = resetn & bus.am_valid & (state_reg == ST_IDLE) &
                   (ev_kind != EV_NONE);

  logic              is_exc_reg;
  logic              bad_we_reg;
  logic [4:0]        excep_code_reg;
  logic [ADDR_W-1:0] epc_reg;
  logic              bd_reg;
  logic [ADDR_W-1:0] badvaddr_reg;
  logic [ADDR_W-1:0] redirect_pc_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  logic commit_exc;
  logic commit_eret;

  always_comb begin
    state_next  = state_reg;
    commit_exc  = 1'b0;
    commit_eret = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (trigger) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit_exc  = is_exc_reg;
        commit_eret = ~is_exc_reg;
        state_next  = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Event fields are captured on the trigger cycle; CP0 values then stay
  // stable until the next exception commit overwrites them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_exc_reg      <= 1'b0;
      bad_we_reg      <= 1'b0;
      excep_code_reg  <= '0;
      epc_reg         <= '0;
      bd_reg          <= 1'b0;
      badvaddr_reg    <= '0;
      redirect_pc_reg <= '0;
    end else if (trigger) begin
      is_exc_reg      <= (ev_kind != EV_ERET);
      redirect_pc_reg <= (ev_kind == EV_ERET) ? bus.epc_in : EXC_VECTOR;
      if (ev_kind != EV_ERET) begin
        excep_code_reg <= (ev_kind == EV_INT) ? EXC_INT : bus.am_excep_code;
        epc_reg        <= bus.am_in_bd ? (bus.am_pc - ADDR_W'(4)) : bus.am_pc;
        bd_reg         <= bus.am_in_bd;
        bad_we_reg     <= (ev_kind == EV_EXC) && has_badvaddr(bus.am_excep_code);
        if ((ev_kind == EV_EXC) && has_badvaddr(bus.am_excep_code)) begin
          // Only a fetch ADEL reports the PC; load ADEL and ADES report the data address.
          badvaddr_reg <= ((bus.am_excep_code == EXC_ADEL) && !bus.am_is_instload)
                          ? bus.am_pc : bus.am_data_addr;
        end
      end else begin
        bad_we_reg <= 1'b0;
      end
    end
  end

  assign busy  = (state_reg != ST_IDLE);
  assign flush = trigger | busy;

  assign bus.redirect_valid  = (state_reg == ST_REDIRECT);
  assign bus.redirect_pc     = redirect_pc_reg;
  assign bus.cp0_we_excep    = commit_exc;
  assign bus.cp0_excep_code  = excep_code_reg;
  assign bus.cp0_epc         = epc_reg;
  assign bus.cp0_bd          = bd_reg;
  assign bus.cp0_we_badvaddr = commit_exc & bad_we_reg;
  assign bus.cp0_badvaddr    = badvaddr_reg;
  assign bus.cp0_clr_exl     = commit_eret;

endmodule
